// File: rtl/router_input_unit.sv
// router_input_unit
//   Input port of a 2D-mesh router. It receives flits over a four-phase
//   req/ack link, queues them in a first-word-fall-through FIFO, and presents
//   the head flit to the switch together with a one-hot XY route request.
//   Wormhole routing: a head flit's route is latched and reused for every
//   body flit until the tail flit leaves. Non-head flits that reach the FIFO
//   front while no packet is open are dropped.
//
// Ports
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   in_req/in_ack  : four-phase link handshake; one flit per transaction
//   in_data        : incoming flit {head, tail, ..., dest_x[7:4], dest_y[3:0]}
//   out_valid      : head flit and route are valid
//   out_ready      : switch takes the head flit this cycle
//   out_data       : FIFO head flit
//   out_route      : one-hot request, bits [4:0] = {W, S, E, N, Local}
//   occupancy      : current FIFO entry count
//   max_occupancy  : occupancy high-water mark (only with ROUTER_INPUT_STATS_EN)
//
// Configuration
//   ROUTER_INPUT_STATS_EN : define to add the max_occupancy statistics port.

module router_input_unit #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int X_COORD = 0,
    parameter int Y_COORD = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_req,
    output logic                     in_ack,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [4:0]               out_route,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef ROUTER_INPUT_STATS_EN
    ,
    output logic [$clog2(DEPTH):0]   max_occupancy
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0] MY_X = 4'(X_COORD);
    localparam logic [3:0] MY_Y = 4'(Y_COORD);

    typedef enum logic { LINK_IDLE, LINK_HOLD } link_state_e;
    typedef enum logic { RT_HEAD,   RT_BODY   } rt_state_e;

    link_state_e       link_state_q, link_state_d;
    logic              in_ack_q, in_ack_d;
    rt_state_e         rt_state_q, rt_state_d;
    logic [4:0]        route_q, route_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic [WIDTH-1:0]  fifo_mem [DEPTH];
    logic [WIDTH-1:0]  front_flit;
    logic              not_empty, full, is_head, is_tail;
    logic              drop, take, pop, push;
    logic [4:0]        calc_route;

    // ------------------------------------------------------------------
    // FIFO front decode and handshake qualifiers
    // ------------------------------------------------------------------
    assign front_flit = fifo_mem[rd_ptr_q];
    assign not_empty  = (count_q != '0);
    assign full       = (count_q == CW'(DEPTH));
    assign is_head    = front_flit[WIDTH-1];
    assign is_tail    = front_flit[WIDTH-2];

    // A stray body flit with no open packet is discarded without being shown.
    assign drop = not_empty && (rt_state_q == RT_HEAD) && !is_head;
    assign take = out_valid && out_ready;
    assign pop  = drop || take;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push = (link_state_q == LINK_IDLE) && in_req && (!full || pop);

    assign out_valid = not_empty && !drop;
    assign out_data  = front_flit;
    assign occupancy = count_q;
    assign in_ack    = in_ack_q;

    // XY dimension-order route of the flit at the FIFO front.
    always_comb begin
        calc_route = 5'b00001;
        if (front_flit[7:4] > MY_X)      calc_route = 5'b00100;
        else if (front_flit[7:4] < MY_X) calc_route = 5'b10000;
        else if (front_flit[3:0] > MY_Y) calc_route = 5'b01000;
        else if (front_flit[3:0] < MY_Y) calc_route = 5'b00010;
    end

    always_comb begin
        out_route = 5'b00000;
        if (out_valid) out_route = (rt_state_q == RT_HEAD) ? calc_route : route_q;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        link_state_d = link_state_q;
        rt_state_d   = rt_state_q;
        route_d      = route_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;

        unique case (link_state_q)
            LINK_IDLE: if (push)    link_state_d = LINK_HOLD;
            LINK_HOLD: if (!in_req) link_state_d = LINK_IDLE;
            default:                link_state_d = LINK_IDLE;
        endcase

        // Pointers wrap naturally since DEPTH is a power of two.
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CW'(push) - CW'(pop);

        if (take) begin
            if (is_tail) begin
                rt_state_d = RT_HEAD;
            end else if (rt_state_q == RT_HEAD) begin
                rt_state_d = RT_BODY;
                route_d    = calc_route;
            end
        end
    end

    assign in_ack_d = (link_state_d == LINK_HOLD);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_state_q <= LINK_IDLE;
            in_ack_q     <= 1'b0;
            rt_state_q   <= RT_HEAD;
            route_q      <= 5'b00000;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            link_state_q <= link_state_d;
            in_ack_q     <= in_ack_d;
            rt_state_q   <= rt_state_d;
            route_q      <= route_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // NOTE: the storage array has no reset; clearing the count is enough to
    // discard its contents, and stale entries are never presented as valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= in_data;
    end

`ifdef ROUTER_INPUT_STATS_EN
    logic [CW-1:0] max_occ_q, max_occ_d;

    // Tracks the post-edge count, so it never reads below occupancy;
    // bounded by DEPTH because the count is.
    assign max_occ_d     = (count_d > max_occ_q) ? count_d : max_occ_q;
    assign max_occupancy = max_occ_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) max_occ_q <= '0;
        else        max_occ_q <= max_occ_d;
    end
`endif

endmodule

// File: doc/router_input_unit.md
ROUTER_INPUT_UNIT -- requirements
Module: router_input_unit

Interface
REQ-001 Parameter WIDTH, default 32: flit width in bits, minimum 10.
REQ-002 Parameter DEPTH, default 4: FIFO entries, power of two, 2..16.
REQ-003 Parameter X_COORD, default 0: this router's column, 4 bits.
REQ-004 Parameter Y_COORD, default 0: this router's row, 4 bits; row numbers increase southward.
REQ-005 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port in_req, input, 1: link request, four-phase, synchronous to clk.
REQ-008 Port in_ack, output, 1: link acknowledge.
REQ-009 Port in_data, input, WIDTH: flit; stable while in_req is high.
REQ-010 Port out_valid, output, 1: FIFO head flit and route are valid.
REQ-011 Port out_ready, input, 1: switch accepts the head flit this cycle.
REQ-012 Port out_data, output, WIDTH: FIFO head flit.
REQ-013 Port out_route, output, 5: one-hot requested output {W,S,E,N,Local} at bits [4:0]=[W,S,E,N,L].
REQ-014 Port occupancy, output, $clog2(DEPTH)+1: current FIFO entry count.

Function
REQ-015 Flit fields SHALL be: bit WIDTH-1 head, bit WIDTH-2 tail, [7:4] dest X, [3:0] dest Y; a single-flit packet has both head and tail set.
REQ-016 Link FSM SHALL have states IDLE and HOLD; IDLE->HOLD when in_req=1 and FIFO not full, writing in_data that cycle; HOLD->IDLE when in_req=0.
REQ-017 in_ack SHALL be 1 exactly in state HOLD (registered, one cycle after capture).
REQ-018 With in_req=1 and FIFO full in IDLE, the FSM SHALL stay in IDLE, write nothing, and keep in_ack=0 until space frees.
REQ-019 Each four-phase transaction SHALL write exactly one flit.
REQ-020 The FIFO SHALL be first-word-fall-through: out_valid=1 whenever occupancy>0, out_data equal to the oldest entry.
REQ-021 A pop SHALL occur when out_valid and out_ready are both 1; out_ready with out_valid=0 has no effect.
REQ-022 A simultaneous push and pop SHALL leave occupancy unchanged; this is legal when the FIFO is full.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH.
REQ-024 The route FSM SHALL have states HEAD and BODY; in HEAD, out_route is computed combinationally from the head flit's dest fields.
REQ-025 Routing SHALL be XY:
  - dest X > X_COORD: E; dest X < X_COORD: W;
  - otherwise dest Y > Y_COORD: S; dest Y < Y_COORD: N;
  - otherwise: L.
REQ-026 Popping a head flit without tail SHALL latch out_route and move to BODY; in BODY, out_route SHALL be the latched value for every flit.
REQ-027 Popping a tail flit SHALL return the route FSM to HEAD.
REQ-028 A non-head flit at the FIFO front in state HEAD SHALL be dropped: popped internally with out_valid=0 for that cycle.
REQ-029 out_route SHALL be 0 when out_valid=0.

Reset
REQ-030 While rst_n=0, the block SHALL hold:
  - link FSM=IDLE, in_ack=0;
  - pointers=0, occupancy=0, out_valid=0;
  - route FSM=HEAD, latched route=0.
REQ-031 Reset assertion mid-transaction SHALL discard all FIFO contents immediately.
REQ-032 After reset release with in_req still high, the block SHALL capture that flit as a new transaction.

Configuration
REQ-033 With macro ROUTER_INPUT_STATS_EN defined, the block SHALL add output port max_occupancy (same width as occupancy):
  - high-water mark of occupancy;
  - reset to 0;
  - saturates at DEPTH.
REQ-034 With ROUTER_INPUT_STATS_EN undefined, the max_occupancy port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Single-flit packet with X_COORD=1, Y_COORD=1, flit head=1, tail=1, dest (3,0) -> in_ack high 1 cycle after in_req, out_route=5'b00100 (E), one pop, FSM stays HEAD.
REQ-036 Three-flit packet with dest (1,3) at router (1,1) -> all three flits show out_route=5'b01000 (S); after the tail pops, the FSM is in HEAD.
REQ-037 DEPTH=4, out_ready=0, five transactions -> four acks, occupancy=4, fifth in_req unacknowledged; one pop -> fifth acked, occupancy=4.
REQ-038 FIFO full with out_ready=1 and a new in_req in the same cycle -> push and pop together, occupancy stays 4, FIFO order preserved.
REQ-039 rst_n pulsed low while in state HOLD with 2 flits stored -> in_ack=0, out_valid=0, occupancy=0 asynchronously.
REQ-040 Body flit (head=0) arriving in state HEAD -> dropped, out_valid never 1 for it, following head flit routed normally.
